// File: rtl/imem_loader.sv
// Purpose: UART boot loader; assembles a length-prefixed image into 32-bit words for instruction memory, holding the core in reset until done.
// Latency: byte valid 2 sync cycles + 9.5 bit periods after a start edge; imem_we/done/err register one cycle after that byte valid.
// Backpressure: none; the UART line cannot be stalled. Optional checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 8,
   parameter int IMEM_WORDS   = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]       MAX_N    = 17'(IMEM_WORDS);

   // ---------------- UART receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

   rx_st_t           rx_st_q;
   logic             rx_s1_q, rx_s2_q, rx_s3_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;

   logic start_edge, rx_start, stop_sample, byte_vld, frame_err;
   logic [7:0] rx_byte;

   assign start_edge  = rx_s3_q & ~rx_s2_q;
   assign rx_start    = (rx_st_q == RX_IDLE) & start_edge;
   assign stop_sample = (rx_st_q == RX_STOP) && (rx_cnt_q == CNT_FULL);
   assign byte_vld    = stop_sample & rx_s2_q;
   assign frame_err   = stop_sample & ~rx_s2_q;
   assign rx_byte     = rx_shift_q;

   // Two-stage synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= uart_rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   // Bit-timing state machine: half-bit start re-check, then mid-bit sampling of data and stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st_q    <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         case (rx_st_q)
            RX_IDLE: begin
               rx_cnt_q <= '0;
               if (start_edge) rx_st_q <= RX_START;
            end
            RX_START: begin
               if (rx_cnt_q == CNT_HALF) begin
                  rx_cnt_q <= '0;
                  rx_bit_q <= '0;
                  // Line back high at half-bit: a glitch, not a start bit.
                  rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == CNT_FULL) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                  else                  rx_bit_q <= rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == CNT_FULL) begin
                  rx_cnt_q <= '0;
                  // Return to idle at mid-stop so a zero-gap next start edge is caught.
                  rx_st_q  <= RX_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CNT_W'(1);
               end
            end
            default: rx_st_q <= RX_IDLE;
         endcase
      end
   end

   // ---------------- Loader FSM ----------------
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE, S_ERROR
   } st_t;

   st_t               st_q;
   logic [7:0]        len_lo_q;
   logic [15:0]       words_left_q;
   logic [1:0]        bcnt_q;
   logic              inc_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;
   logic              core_rst_n_q, busy_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chk_q;
`endif

   logic [15:0] n_full;
   assign n_full = {rx_byte, len_lo_q};

   // Image parser with registered outputs; DONE and ERROR are left only by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= S_IDLE;
         len_lo_q     <= '0;
         words_left_q <= '0;
         bcnt_q       <= '0;
         inc_q        <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;
         // Advance the word index only after the write cycle so addr is stable during imem_we.
         if (inc_q) begin
            imem_addr_q <= imem_addr_q + ADDR_W'(1);
            inc_q       <= 1'b0;
         end
         case (st_q)
            S_IDLE: begin
               if (rx_start) begin
                  st_q   <= S_LEN_LO;
                  busy_q <= 1'b1;
               end
            end
            S_LEN_LO: begin
               if (frame_err) begin
                  st_q <= S_ERROR; err_q <= 1'b1; busy_q <= 1'b0;
               end else if (byte_vld) begin
                  len_lo_q <= rx_byte;
`ifdef LOADER_CHECKSUM_EN
                  chk_q    <= rx_byte;
`endif
                  st_q     <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (frame_err) begin
                  st_q <= S_ERROR; err_q <= 1'b1; busy_q <= 1'b0;
               end else if (byte_vld) begin
`ifdef LOADER_CHECKSUM_EN
                  chk_q <= chk_q ^ rx_byte;
`endif
                  if (n_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     st_q <= S_CHK;
`else
                     st_q <= S_DONE; done_q <= 1'b1; core_rst_n_q <= 1'b1; busy_q <= 1'b0;
`endif
                  end else if ({1'b0, n_full} > MAX_N) begin
                     st_q <= S_ERROR; err_q <= 1'b1; busy_q <= 1'b0;
                  end else begin
                     words_left_q <= n_full;
                     bcnt_q       <= '0;
                     st_q         <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (frame_err) begin
                  st_q <= S_ERROR; err_q <= 1'b1; busy_q <= 1'b0;
               end else if (byte_vld) begin
`ifdef LOADER_CHECKSUM_EN
                  chk_q <= chk_q ^ rx_byte;
`endif
                  imem_wdata_q[{bcnt_q, 3'b000} +: 8] <= rx_byte;
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     imem_we_q <= 1'b1;
                     if (words_left_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        st_q <= S_CHK;
`else
                        st_q <= S_DONE; done_q <= 1'b1; core_rst_n_q <= 1'b1; busy_q <= 1'b0;
`endif
                     end else begin
                        words_left_q <= words_left_q - 16'd1;
                        inc_q        <= 1'b1;
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (frame_err || (byte_vld && (rx_byte != chk_q))) begin
                  st_q <= S_ERROR; err_q <= 1'b1; busy_q <= 1'b0;
               end else if (byte_vld) begin
                  st_q <= S_DONE; done_q <= 1'b1; core_rst_n_q <= 1'b1; busy_q <= 1'b0;
               end
            end
`endif
            S_DONE:  st_q <= S_DONE;
            S_ERROR: st_q <= S_ERROR;
            default: st_q <= S_ERROR;
         endcase
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle RISC-V core's instruction memory. Receives a length-prefixed program image over a UART line, assembles little-endian 32-bit words and writes them into instruction memory. It holds the core in reset until the whole image has been written, then releases it. Framing, length and (optionally) checksum errors are reported and keep the core held.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit; 100 MHz / 115200 baud; legal values ≥ 4.
- `ADDR_W`, 8, width of the word address into instruction memory.
- `IMEM_WORDS`, 256, capacity in words; must be ≤ 2^ADDR_W.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: **asynchronous, active-low reset**.
- `uart_rx` input 1: asynchronous serial input, 8N1, idle high.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output ADDR_W: word address; byte address = imem_addr×4.
- `imem_wdata` output 32: word to write.
- `core_rst_n` output 1: active-low hold for the core; low until load completes.
- `busy` output 1: high from the first header byte until DONE or ERROR.
- `done` output 1: sticky, high once the image is fully written and accepted.
- `err` output 1: sticky, high on framing, length or checksum error.

## Operation
- Image format: LEN_LO, LEN_HI (word count N, little-endian), then N words of 4 bytes each, LSB first. With the checksum feature enabled, one trailing CHK byte follows.
- RX path:
  - 2-FF synchronizer on `uart_rx`.
  - Start detected on a synchronized high→low edge. The start bit is re-checked at half-bit (CLKS_PER_BIT/2); if the line is high there, the start is treated as a glitch and the receiver returns to idle.
  - 8 data bits sampled at mid-bit, LSB first. The stop bit is sampled at mid-bit.
  - A stop bit of 0 is a framing error.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR.
  - IDLE→LEN_LO on the first start bit.
  - LEN_LO→LEN_HI on byte valid.
  - LEN_HI→DATA on byte valid when 0 < N ≤ IMEM_WORDS.
  - N = 0 → DONE, or CHK when the checksum feature is enabled.
  - N > IMEM_WORDS → ERROR.
  - DATA: a byte counter 0..3 shifts each byte into `imem_wdata[8k+7:8k]`. On the 4th byte, pulse `imem_we` and increment the word index. After word N−1, go to DONE (or CHK).
  - CHK→DONE on match; CHK→ERROR on mismatch.
  - Any framing error in any receiving state → ERROR.
- DONE and ERROR are terminal. Only `rst_n` leaves them, and further `uart_rx` traffic is ignored.
- `imem_addr` = current word index, starting at 0. It never exceeds N−1 and never wraps.
- `core_rst_n` = 1 only in DONE. `busy` = 1 in LEN_LO..CHK. `err` = 1 only in ERROR.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst_n`=0, `busy`=0, `done`=0, `err`=0. The FSM is in IDLE and the RX block is idle.
- `rst_n` assertion mid-load aborts immediately. Words already written stay in memory, the word index clears, and the core is held again.
- Byte valid is generated internally in the cycle the stop bit is sampled: 2 sync cycles + 9.5 bit periods after the start edge.
- `imem_we` rises in the cycle after the byte valid for the 4th byte of a word and is high for exactly 1 cycle. `imem_addr` and `imem_wdata` are stable and registered in that cycle.
- `core_rst_n`, `done` and `err` change in the cycle after the last qualifying byte valid (the CHK byte, LEN_HI when N = 0, or the 4th byte of word N−1). They are registered and glitch-free.
- Back-to-back bytes with zero idle time between stop and start are required to work.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CHK state compiled in.
  - Running XOR over all bytes, including the two length bytes, is compared with the trailing CHK byte.
  - Mismatch → ERROR, with `done`=0 and `core_rst_n` held low. Words already written remain in memory.
- `LOADER_CHECKSUM_EN` undefined: no CHK state and no accumulator. DONE follows the last data byte directly, and any byte after it is ignored.

## Test plan
- Reset then idle line for 20 bit periods → all outputs at their reset values, no `imem_we`.
- Send N=2 and words 0x00500093 and 0x00A00113 (plus CHK = XOR of all 10 bytes when enabled):
  - exactly 2 `imem_we` pulses, at addr 0 (wdata 0x00500093) and addr 1 (wdata 0x00A00113);
  - then `done`=1 and `core_rst_n`=1 one cycle after the final byte.
- Send LEN = 0x0101 (257) with IMEM_WORDS=256 → `err`=1 after LEN_HI, no `imem_we`, `core_rst_n`=0.
- Send a byte with the stop bit driven low inside word 0 → `err`=1, `busy`=0, and no `imem_we` for that word.
- With `LOADER_CHECKSUM_EN`, send N=1, word 0x12345678, CHK = correct value XOR 0x01 → one `imem_we` at addr 0, then `err`=1 and `done`=0.
- Assert `rst_n` low after 5 of 8 data bytes, release it, then send a full N=1 image → addr restarts at 0 and `done`=1 with correct data.
